mem_arbiter: RTL

Two-port arbiter and sequencer for the single-bus RAM in the cuca1 core. It accepts independent read/write requests from port 0 (CPU) and port 1 (loader/debug). It grants one at a time and drives the RAM's `enable`/`rw`/shared-bus protocol through a fixed address phase and data phase. The requester receives a one-cycle completion pulse, plus read data for reads.

---
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-port arbiter and sequencer for the single-bus RAM of the cuca1 core.
//   Port 0 is the CPU, port 1 the loader/debug channel. One request is granted
//   at a time. The granted request then runs through a fixed four-state
//   sequence: IDLE -> ADDR -> DATA -> RESP. In ADDR the address is driven on
//   the shared bus. In DATA the write data is driven, or for a read the bus is
//   released and sampled. In RESP the bus stays released and the requester
//   gets a one-cycle completion pulse (with read data for reads).
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIORITY_EN
//     undefined : round-robin arbitration using a 1-bit last-winner pointer.
//     defined   : port 0 always wins a contested arbitration, and no pointer
//                 is built. Port 1 can starve, which is acceptable while the
//                 CPU is halted for loading.
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   n_reset      synchronous active-low reset
//   req_valid    per-port request (bit i = port i)
//   req_rw       per-port direction, 1 = write
//   req_addr0/1  per-port address
//   req_wdata0/1 per-port write data
//   req_grant    one-hot grant pulse, combinational in IDLE
//   req_done     one-hot completion pulse during RESP
//   rdata        captured read data, valid while req_done is high
//   busy         high whenever the sequencer is not IDLE
//   mem_enable   RAM enable
//   mem_rw       RAM direction, 1 = write
//   mem_bus_out  value driven onto the shared RAM bus
//   mem_bus_oe   bus output enable (bus released when low)
//   mem_bus_in   RAM bus as seen by the arbiter
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BITW = 8
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_rw,
    input  logic [BITW-1:0] req_addr0,
    input  logic [BITW-1:0] req_addr1,
    input  logic [BITW-1:0] req_wdata0,
    input  logic [BITW-1:0] req_wdata1,
    output logic [1:0]      req_grant,
    output logic [1:0]      req_done,
    output logic [BITW-1:0] rdata,
    output logic            busy,
    output logic            mem_enable,
    output logic            mem_rw,
    output logic [BITW-1:0] mem_bus_out,
    output logic            mem_bus_oe,
    input  logic [BITW-1:0] mem_bus_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic            winner_q, winner_d;
    logic            rw_q,     rw_d;
    logic [BITW-1:0] addr_q,   addr_d;
    logic [BITW-1:0] wdata_q,  wdata_d;
    logic [BITW-1:0] rdata_q,  rdata_d;

    logic            winner;
    logic            grantFire;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic            lastWinner_q, lastWinner_d;
`endif

    // Pick the port that would win if a grant were issued this cycle.
    // In round-robin mode, a contested request goes to the port that did not
    // win last time. A single requester always wins.
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = req_valid[0] ? 1'b0 : 1'b1;
    end
`else
    always_comb begin
        if (req_valid == 2'b11) begin
            winner = ~lastWinner_q;
        end else begin
            winner = req_valid[1];
        end
    end
`endif

    // A grant happens only from IDLE, and only outside reset. Gating with
    // n_reset keeps req_grant low for as long as reset is held.
    assign grantFire = n_reset && (state_q == ST_IDLE) && (|req_valid);

    always_comb begin
        req_grant = 2'b00;
        if (grantFire) begin
            req_grant = winner ? 2'b10 : 2'b01;
        end
    end

    // Next-state logic. The request fields are copied into private registers
    // at grant time. This way a requester that changes or drops its inputs
    // after the grant does not disturb the transaction in flight.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        lastWinner_d = lastWinner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d  = ST_ADDR;
                    winner_d = winner;
                    rw_d     = req_rw[winner];
                    addr_d   = winner ? req_addr1  : req_addr0;
                    wdata_d  = winner ? req_wdata1 : req_wdata0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    lastWinner_d = winner;
`endif
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                // The RAM drives the bus during a read DATA cycle. The value
                // is sampled at the closing edge and held for RESP.
                if (!rw_q) begin
                    rdata_d = mem_bus_in;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset is synchronous, so a reset in the middle of a
    // transaction simply drops the sequencer back to IDLE at the next edge,
    // and no completion pulse is issued.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            winner_q <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    // The pointer resets to port 1, so port 0 wins the first contested
    // arbitration after reset.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            lastWinner_q <= 1'b1;
        end else begin
            lastWinner_q <= lastWinner_d;
        end
    end
`endif

    // RAM-side outputs are decoded from registered state only, so there is no
    // path from req_* straight through to mem_*. The bus is released for the
    // whole read DATA cycle and all of RESP, which gives the RAM and the
    // arbiter a clean turnaround.
    always_comb begin
        mem_enable  = 1'b0;
        mem_rw      = 1'b0;
        mem_bus_oe  = 1'b0;
        mem_bus_out = '0;
        req_done    = 2'b00;
        case (state_q)
            ST_ADDR: begin
                mem_enable  = 1'b1;
                mem_rw      = rw_q;
                mem_bus_oe  = 1'b1;
                mem_bus_out = addr_q;
            end
            ST_DATA: begin
                mem_enable = 1'b1;
                mem_rw     = rw_q;
                if (rw_q) begin
                    mem_bus_oe  = 1'b1;
                    mem_bus_out = wdata_q;
                end
            end
            ST_RESP: begin
                req_done = winner_q ? 2'b10 : 2'b01;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign rdata = rdata_q;

endmodule
